// File: rtl/instr_dispatcher.sv
// In-order issue controller between the instruction FIFO and the TPU execution
// units. It decodes the FIFO head and checks unit-busy and weight/matmul
// hazards. Each accepted instruction is popped in the cycle it is accepted and
// is issued as a one-cycle pulse on the next cycle. The block also handles the
// NOP, SYNC and HALT control instructions.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   instr_in, fifo_empty FIFO head (first-word-fall-through) and empty flag
//   fifo_next_en         combinational pop strobe, one cycle per accepted head
//   *_busy               execution unit busy flags
//   resume               leaves the HALTED state
//   instr_out            copy of the last issued instruction
//   *_issue              one-cycle start pulses
//   halted, idle         status outputs
//   illegal_op           sticky flag, set when an illegal opcode is popped
//
// Optional: define DISPATCH_STATS_EN to add the issue_count and stall_count
// statistics counters. These counters are sized by CNT_WIDTH.
module instr_dispatcher #(
  parameter int unsigned INSTR_WIDTH = 80
`ifdef DISPATCH_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH   = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   fifo_empty,
  output logic                   fifo_next_en,
  input  logic                   weight_busy,
  input  logic                   matmul_busy,
  input  logic                   act_busy,
  input  logic                   resume,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   weight_issue,
  output logic                   matmul_issue,
  output logic                   act_issue,
  output logic                   halted,
  output logic                   idle,
  output logic                   illegal_op
`ifdef DISPATCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]   issue_count,
  output logic [CNT_WIDTH-1:0]   stall_count
`endif
);

  localparam int unsigned OP_WIDTH = 8;
  localparam int unsigned N_UNITS  = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_SYNC,
    ST_HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_SYNC,
    OP_LOAD_WEIGHT,
    OP_MATMUL,
    OP_ACTIVATE,
    OP_HALT,
    OP_ILLEGAL
  } op_class_t;

  state_t              state;
  state_t              state_next;
  op_class_t           op_class;
  logic [OP_WIDTH-1:0] opcode;
  logic                accept;
  logic                set_illegal;
  logic [N_UNITS-1:0]  issue_next;     // {act, matmul, weight}
  logic                eff_weight;
  logic                eff_matmul;
  logic                eff_act;

  // The unit latches its start pulse one cycle before its busy flag rises.
  // The issue pulse register therefore doubles as the pending flag.
  assign eff_weight = weight_busy | weight_issue;
  assign eff_matmul = matmul_busy | matmul_issue;
  assign eff_act    = act_busy    | act_issue;

  assign opcode = instr_in[INSTR_WIDTH-1 -: OP_WIDTH];

  // Opcode decode
  always_comb begin
    op_class = OP_ILLEGAL;
    if (opcode == 8'h00)                op_class = OP_NOP;
    else if (opcode == 8'h01)           op_class = OP_SYNC;
    else if (opcode[7:3] == 5'b0_0001)  op_class = OP_LOAD_WEIGHT;
    else if (opcode[7:4] == 4'h2)       op_class = OP_MATMUL;
    else if (opcode[7:4] == 4'h4)       op_class = OP_ACTIVATE;
    else if (opcode == 8'hFF)           op_class = OP_HALT;
  end

  // Next-state, accept and issue selection
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    set_illegal  = 1'b0;
    issue_next   = '0;
    fifo_next_en = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (!fifo_empty) begin
          unique case (op_class)
            OP_NOP: accept = 1'b1;
            OP_SYNC: begin
              accept     = 1'b1;
              state_next = ST_WAIT_SYNC;
            end
            OP_HALT: begin
              accept     = 1'b1;
              state_next = ST_HALTED;
            end
            // Weights must not change under an active multiply.
            OP_LOAD_WEIGHT: begin
              if (!eff_weight && !eff_matmul) begin
                accept     = 1'b1;
                issue_next = 3'b001;
              end
            end
            OP_MATMUL: begin
              if (!eff_matmul && !eff_weight) begin
                accept     = 1'b1;
                issue_next = 3'b010;
              end
            end
            OP_ACTIVATE: begin
              if (!eff_act && !eff_matmul) begin
                accept     = 1'b1;
                issue_next = 3'b100;
              end
            end
            default: begin
              accept      = 1'b1;
              set_illegal = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT_SYNC: begin
        if (!eff_weight && !eff_matmul && !eff_act) state_next = ST_RUN;
      end
      ST_HALTED: begin
        if (resume) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    fifo_next_en = accept && !rst;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out    <= '0;
      weight_issue <= 1'b0;
      matmul_issue <= 1'b0;
      act_issue    <= 1'b0;
      halted       <= 1'b0;
      idle         <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      weight_issue <= issue_next[0];
      matmul_issue <= issue_next[1];
      act_issue    <= issue_next[2];
      if (issue_next != '0) instr_out <= instr_in;
      halted       <= (state_next == ST_HALTED);
      idle         <= (state == ST_RUN) && fifo_empty &&
                      !eff_weight && !eff_matmul && !eff_act;
      illegal_op   <= illegal_op | set_illegal;
    end
  end

`ifdef DISPATCH_STATS_EN
  // Statistics counters. Issue pulses only ever occur in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      if (weight_issue || matmul_issue || act_issue)
        issue_count <= issue_count + CNT_WIDTH'(1);
      if ((state == ST_RUN) && !fifo_empty && !accept)
        stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_dispatcher.sv
// Bench for instr_dispatcher. A queue models the FIFO. A scoreboard records
// each observed pop and the issue pulse that must follow on the next cycle.
// The bench applies a table of single-instruction vectors and then several
// hand-written multi-cycle sequences.
module tb_instr_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] instr_in;
  logic        fifo_empty;
  logic        fifo_next_en;
  logic        weight_busy, matmul_busy, act_busy, resume;
  logic [79:0] instr_out;
  logic        weight_issue, matmul_issue, act_issue;
  logic        halted, idle, illegal_op;
`ifdef DISPATCH_STATS_EN
  logic [31:0] issue_count, stall_count;
`endif

  instr_dispatcher dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .fifo_empty(fifo_empty),
    .fifo_next_en(fifo_next_en), .weight_busy(weight_busy),
    .matmul_busy(matmul_busy), .act_busy(act_busy), .resume(resume),
    .instr_out(instr_out), .weight_issue(weight_issue),
    .matmul_issue(matmul_issue), .act_issue(act_issue), .halted(halted),
    .idle(idle), .illegal_op(illegal_op)
`ifdef DISPATCH_STATS_EN
    , .issue_count(issue_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [2:0]  pulses;   // {act, matmul, weight}
    logic [79:0] instr;
  } exp_t;

  typedef struct {
    logic [7:0] op;
    logic       wb, mb, ab;
    logic       pop;
    logic [2:0] unit;
  } vec_t;

  logic [79:0] fq[$];
  exp_t        sb[$];
  vec_t        vt[18];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Snapshot of DUT outputs at the most recent falling edge
  logic        s_pop, s_halted, s_idle, s_ill;
  logic [2:0]  s_pulses;
  logic [79:0] s_instr_out;
`ifdef DISPATCH_STATS_EN
  logic [31:0] s_stall;
`endif

  function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic logic [2:0] unit_of(logic [7:0] op);
    if (op[7:3] == 5'b00001) return 3'b001;
    if (op[7:4] == 4'h2)     return 3'b010;
    if (op[7:4] == 4'h4)     return 3'b100;
    return 3'b000;
  endfunction

  task automatic drive_head();
    if (fq.size() > 0) begin
      instr_in   = fq[0];
      fifo_empty = 1'b0;
    end else begin
      instr_in   = '0;
      fifo_empty = 1'b1;
    end
  endtask

  task automatic push(logic [79:0] ins);
    fq.push_back(ins);
    drive_head();
  endtask

  task automatic set_busy(logic wb, logic mb, logic ab);
    weight_busy = wb;
    matmul_busy = mb;
    act_busy    = ab;
  endtask

  // One clock: sample, score the issue pulses, model the FIFO pop.
  task automatic cycle();
    exp_t       e;
    logic [2:0] exp_p;
    @(negedge clk);
    s_pop       = fifo_next_en;
    s_halted    = halted;
    s_idle      = idle;
    s_ill       = illegal_op;
    s_pulses    = {act_issue, matmul_issue, weight_issue};
    s_instr_out = instr_out;
`ifdef DISPATCH_STATS_EN
    s_stall     = stall_count;
`endif
    exp_p = 3'b000;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_p = e.pulses;
      if (exp_p != 3'b000) chk("instr_out", s_instr_out, e.instr);
    end
    chk("issue_pulses", 80'(s_pulses), 80'(exp_p));
    if (s_pop && fq.size() > 0)
      sb.push_back('{due: cyc + 1, pulses: unit_of(fq[0][79:72]), instr: fq[0]});
    cyc++;
    @(posedge clk);
    #1;
    if (s_pop && fq.size() > 0) begin
      void'(fq.pop_front());
      drive_head();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] pl;
    int k;
    logic found;
`ifdef DISPATCH_STATS_EN
    logic [31:0] base;
`endif
    vt[0]  = '{8'h0A, 0, 0, 0, 1, 3'b001};
    vt[1]  = '{8'h08, 0, 1, 0, 0, 3'b000};
    vt[2]  = '{8'h0F, 1, 0, 0, 0, 3'b000};
    vt[3]  = '{8'h0F, 0, 0, 1, 1, 3'b001};
    vt[4]  = '{8'h20, 0, 0, 0, 1, 3'b010};
    vt[5]  = '{8'h2F, 1, 0, 0, 0, 3'b000};
    vt[6]  = '{8'h21, 0, 0, 1, 1, 3'b010};
    vt[7]  = '{8'h40, 0, 0, 0, 1, 3'b100};
    vt[8]  = '{8'h4F, 0, 1, 0, 0, 3'b000};
    vt[9]  = '{8'h45, 0, 0, 1, 0, 3'b000};
    vt[10] = '{8'h4F, 1, 0, 0, 1, 3'b100};
    vt[11] = '{8'h00, 1, 1, 1, 1, 3'b000};
    vt[12] = '{8'h01, 1, 1, 1, 1, 3'b000};
    vt[13] = '{8'h07, 0, 0, 0, 1, 3'b000};
    vt[14] = '{8'h10, 0, 0, 0, 1, 3'b000};
    vt[15] = '{8'h30, 0, 0, 0, 1, 3'b000};
    vt[16] = '{8'h50, 0, 0, 0, 1, 3'b000};
    vt[17] = '{8'hFE, 0, 0, 0, 1, 3'b000};

    // Reset with a nonempty FIFO
    rst = 1'b1;
    resume = 1'b0;
    set_busy(0, 0, 0);
    push(80'h0A00_0000_0000_0000_0001);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_pop", 80'(s_pop), 80'(0));
      chk("rst_instr_out", s_instr_out, 80'h0);
      chk("rst_halted", 80'(s_halted), 80'(0));
      chk("rst_illegal", 80'(s_ill), 80'(0));
    end
    fq.delete();
    drive_head();
    rst = 1'b0;
    cycle();
    cycle();
    chk("idle_after_rst", 80'(s_idle), 80'(1));

    // Table-driven single-instruction vectors
    for (int i = 0; i < 18; i++) begin
      pl = (i == 0) ? 72'h1 : {$urandom, $urandom, 8'(i)};
      set_busy(vt[i].wb, vt[i].mb, vt[i].ab);
      push({vt[i].op, pl});
      cycle();
      chk($sformatf("vec%0d_pop", i), 80'(s_pop), 80'(vt[i].pop));
      set_busy(0, 0, 0);
      fq.delete();
      drive_head();
      cycle();
      chk($sformatf("vec%0d_unit", i), 80'(s_pulses), 80'(vt[i].unit));
      cycle();
    end
    chk("illegal_sticky_table", 80'(s_ill), 80'(1));

    // MATMUL held off by the weight loader for 5 cycles
    set_busy(1, 0, 0);
    push({8'h21, 72'hABCDEF});
    for (int i = 0; i < 5; i++) begin
      cycle();
`ifdef DISPATCH_STATS_EN
      if (i == 0) base = s_stall;
`endif
      chk("mm_stall_pop", 80'(s_pop), 80'(0));
    end
    set_busy(0, 0, 0);
    cycle();
    chk("mm_release_pop", 80'(s_pop), 80'(1));
`ifdef DISPATCH_STATS_EN
    chk("stall_count", 80'(s_stall - base), 80'(5));
`endif
    cycle();
    cycle();

    // SYNC followed by ACTIVATE while the matrix unit is busy
    set_busy(0, 1, 0);
    push({8'h01, 72'h0});
    push({8'h40, 72'h1234_5678});
    cycle();
    chk("sync_pop", 80'(s_pop), 80'(1));
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("sync_hold", 80'(s_pop), 80'(0));
    end
    set_busy(0, 0, 0);
    found = 1'b0;
    k = 0;
    while (!found && k < 6) begin
      cycle();
      if (s_pop) found = 1'b1;
      else k++;
    end
    chk("sync_act_popped", 80'(found), 80'(1));
    chk("sync_release_delay", 80'(k), 80'(1));
    cycle();
    cycle();

    // HALT followed by LOAD_WEIGHT, released by resume
    push({8'hFF, 72'h0});
    push({8'h08, 72'h77});
    cycle();
    chk("halt_pop", 80'(s_pop), 80'(1));
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("halted_hold", 80'(s_halted), 80'(1));
      chk("halted_nopop", 80'(s_pop), 80'(0));
    end
    resume = 1'b1;
    cycle();
    chk("resume_cycle_pop", 80'(s_pop), 80'(0));
    resume = 1'b0;
    cycle();
    chk("resumed_halted", 80'(s_halted), 80'(0));
    chk("resumed_pop", 80'(s_pop), 80'(1));
    cycle();
    cycle();

    // Illegal opcode then NOP after a fresh reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("ill_cleared", 80'(s_ill), 80'(0));
    push({8'h55, 72'h0});
    push({8'h00, 72'h0});
    cycle();
    chk("ill_pop", 80'(s_pop), 80'(1));
    cycle();
    chk("nop_pop", 80'(s_pop), 80'(1));
    chk("ill_set", 80'(s_ill), 80'(1));
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("ill_sticky", 80'(s_ill), 80'(1));
    end
    chk("sb_drained", 80'(sb.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
Name: instr_dispatcher

Overview:
In-order issue controller between the instruction FIFO and the TPU execution units (weight loader, matrix-multiply unit, activation unit). Reads the first-word-fall-through FIFO head, decodes the opcode and checks unit busy and data hazards. Issues each instruction as a registered one-cycle pulse to exactly one unit and pops the FIFO in the same cycle it accepts the head. Also handles the SYNC, HALT and NOP control instructions.

Parameters:
INSTR_WIDTH, 80, instruction width. Fixed layout: opcode [79:72], remaining bits opaque to this block.
CNT_WIDTH, 32, width of the statistics counters (Optional Feature only).

Ports:
clk  in  1  clock
rst  in  1  reset. Synchronous, active-high.
instr_in  in  INSTR_WIDTH  FIFO head (data_out); valid when fifo_empty=0
fifo_empty  in  1  FIFO empty flag
fifo_next_en  out  1  pop strobe to FIFO; combinational, 1 cycle per accepted instruction
weight_busy  in  1  weight loader busy
matmul_busy  in  1  matrix unit busy
act_busy  in  1  activation unit busy
resume  in  1  leave HALTED state
instr_out  out  INSTR_WIDTH  registered copy of the last issued instruction
weight_issue  out  1  1-cycle start pulse to weight loader
matmul_issue  out  1  1-cycle start pulse to matrix unit
act_issue  out  1  1-cycle start pulse to activation unit
halted  out  1  high while in HALTED
idle  out  1  RUN, FIFO empty, all units not busy, no pending issue
illegal_op  out  1  sticky flag; cleared only by rst

Behaviour:
- Reset values: all outputs 0, instr_out=0, state=RUN, pending flags cleared. fifo_next_en=0 while rst=1. Reset mid-operation abandons an in-flight SYNC or HALT.
- Decode on instr_in[79:72]:
  - 0x00: NOP
  - 0x01: SYNC
  - 0x08-0x0F: LOAD_WEIGHT
  - 0x20-0x2F: MATMUL
  - 0x40-0x4F: ACTIVATE
  - 0xFF: HALT
  - anything else: illegal
- eff_busy(u) = u_busy OR pend_u. pend_u is set in the cycle after an issue to u, covering the unit's 1-cycle busy latency.
- Issue conditions in RUN with fifo_empty=0:
  - LOAD_WEIGHT: NOT eff_busy(weight) AND NOT eff_busy(matmul). Weights must not change under an active multiply.
  - MATMUL: NOT eff_busy(matmul) AND NOT eff_busy(weight).
  - ACTIVATE: NOT eff_busy(act) AND NOT eff_busy(matmul).
- On accept: fifo_next_en=1 that cycle. Next cycle, the unit's issue pulse is 1 and instr_out=instr_in. Issue latency is 1 cycle after acceptance.
- Otherwise the head stalls: no pop, no pulse. Strict in-order; a blocked head blocks everything behind it.
- NOP: popped, no issue, 1 cycle.
- Illegal opcode: popped, no issue, illegal_op <= 1 (sticky).
- SYNC: popped, then state WAIT_SYNC. Return to RUN in the first cycle where all eff_busy are 0. No pop and no issue while in WAIT_SYNC.
- HALT: popped, then state HALTED with halted=1. resume=1 returns to RUN next cycle. resume is ignored outside HALTED.
- FIFO empty: no pop. instr_in is ignored.
- At most one pop and one issue pulse per cycle.

Optional Feature:
Macro DISPATCH_STATS_EN.
- Defined: adds output issue_count[CNT_WIDTH-1:0] (increments per issue pulse) and output stall_count[CNT_WIDTH-1:0] (increments each RUN cycle where fifo_empty=0 and the head is not accepted). Both counters wrap at 2^CNT_WIDTH, reset to 0 on rst, and do not count during WAIT_SYNC or HALTED.
- Not defined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst high 2 cycles with a nonempty FIFO -> fifo_next_en stays 0, all issue pulses and instr_out are 0, idle=1 once FIFO is empty.
- Head 80'h0A00_0000_0000_0000_0001, all units idle -> fifo_next_en=1 in cycle N, weight_issue=1 and instr_out equal to the head in cycle N+1, single pulse.
- Head MATMUL 0x21 while weight_busy=1 for 5 cycles -> no pop for 5 cycles; issue one cycle after weight_busy falls. With DISPATCH_STATS_EN, stall_count=5.
- Sequence SYNC then ACTIVATE 0x40 while matmul_busy=1 for 3 cycles -> SYNC popped; ACTIVATE held in FIFO until matmul_busy=0, then act_issue pulses.
- Sequence HALT then LOAD_WEIGHT 0x08 -> halted=1 and no further pops; resume pulse -> halted=0, weight_issue one cycle after the pop.
- Head 0x55 then NOP 0x00 -> both popped on consecutive cycles, illegal_op=1 and stays 1, no issue pulses.
